// File: rtl/mult_pipe.sv
// Pipelined shift-and-add multiplier: STAGES slices of WIDTH/STAGES multiplier bits,
// signed operands handled as magnitudes with the sign applied in the final stage.
module mult_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 8,
  parameter int TAG_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  input  logic             in_high,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int NS = (STAGES < 1) ? 1 : STAGES;
  localparam int SL = WIDTH / NS;
  localparam int PW = 2 * WIDTH;

  generate
    if (STAGES < 1) begin : g_bad_stages
      $error("mult_pipe: STAGES must be at least 1");
    end else if (WIDTH % STAGES != 0) begin : g_bad_width
      $error("mult_pipe: WIDTH must be a multiple of STAGES");
    end
  endgenerate

  logic             advance;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [NS-1:0]    vld;
  logic [NS-1:0]    neg;
  logic [NS-1:0]    hi;
  logic [PW-1:0]    acc [NS];
  logic [PW-1:0]    mc  [NS];
  logic [WIDTH-1:0] mp  [NS];
  logic [TAG_W-1:0] tag [NS];

  logic [PW-1:0]    acc_d [NS];
  logic [PW-1:0]    mc_d  [NS];
  logic [WIDTH-1:0] mp_d  [NS];
  logic [NS-1:0]    neg_d;

  // Global stall: nothing moves while the output holds an untaken result.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  assign a_neg = in_signed & in_a[WIDTH-1];
  assign b_neg = in_signed & in_b[WIDTH-1];
  assign a_mag = a_neg ? (~in_a + 1'b1) : in_a;
  assign b_mag = b_neg ? (~in_b + 1'b1) : in_b;

  genvar k;
  generate
    for (k = 0; k < NS; k++) begin : g_stage
      logic [PW-1:0]    src_acc;
      logic [PW-1:0]    src_mc;
      logic [WIDTH-1:0] src_mp;
      logic [PW-1:0]    sum;

      if (k == 0) begin : g_first
        assign src_acc  = '0;
        assign src_mc   = {{WIDTH{1'b0}}, a_mag};
        assign src_mp   = b_mag;
        assign neg_d[k] = a_neg ^ b_neg;
      end else begin : g_next
        assign src_acc  = acc[k-1];
        assign src_mc   = mc[k-1];
        assign src_mp   = mp[k-1];
        assign neg_d[k] = neg[k-1];
      end

      assign sum     = src_acc + (PW'(src_mp[SL-1:0]) * src_mc);
      assign mc_d[k] = src_mc << SL;
      assign mp_d[k] = src_mp >> SL;

      if (k == NS - 1) begin : g_sign
        assign acc_d[k] = neg_d[k] ? (~sum + 1'b1) : sum;
      end else begin : g_plain
        assign acc_d[k] = sum;
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= '0;
      neg <= '0;
      hi  <= '0;
      for (int i = 0; i < NS; i++) begin
        acc[i] <= '0;
        mc[i]  <= '0;
        mp[i]  <= '0;
        tag[i] <= '0;
      end
    end else if (advance) begin
      vld[0] <= in_valid;
      neg[0] <= neg_d[0];
      hi[0]  <= in_high;
      tag[0] <= in_tag;
      for (int i = 1; i < NS; i++) begin
        vld[i] <= vld[i-1];
        neg[i] <= neg_d[i];
        hi[i]  <= hi[i-1];
        tag[i] <= tag[i-1];
      end
      for (int i = 0; i < NS; i++) begin
        acc[i] <= acc_d[i];
        mc[i]  <= mc_d[i];
        mp[i]  <= mp_d[i];
      end
    end
  end

  // The last stage already holds the signed full product; only half selection remains.
  assign out_valid  = vld[NS-1];
  assign out_result = hi[NS-1] ? acc[NS-1][PW-1:WIDTH] : acc[NS-1][WIDTH-1:0];
  assign out_tag    = tag[NS-1];
  assign busy       = |vld;

endmodule

// File: tb/tb_mult_pipe.sv
// Bench for mult_pipe: directed corner products, stall/reset scenarios and random
// traffic scored against a 128-bit arithmetic reference queue.
module tb_mult_pipe;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        in_valid, in_ready, in_signed, in_high;
  logic [63:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready, busy;
  logic [63:0] out_result;
  logic [3:0]  out_tag;

  logic        s_in_valid, s_in_ready, s_in_signed, s_in_high;
  logic [31:0] s_in_a, s_in_b;
  logic [3:0]  s_in_tag;
  logic        s_out_valid, s_out_ready, s_busy;
  logic [31:0] s_out_result;
  logic [3:0]  s_out_tag;

  mult_pipe dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_high(in_high), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  mult_pipe #(.WIDTH(32), .STAGES(4), .TAG_W(4)) dut_small (
    .clock(clock), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_signed(s_in_signed), .in_high(s_in_high), .in_tag(s_in_tag),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_result(s_out_result), .out_tag(s_out_tag), .busy(s_busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int popped = 0;

  always @(posedge clock) cyc++;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input logic h);
    logic [127:0] p;
    if (s) p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    else   p = {64'd0, a} * {64'd0, b};
    return h ? p[127:64] : p[63:0];
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = '1;
      2: v = 64'h8000_0000_0000_0000;
      3: v = {{48{1'b1}}, 16'($urandom)};
      4: v = 64'($urandom_range(0, 1000));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  typedef struct { logic [63:0] res; logic [3:0] tag; } exp_t;
  exp_t q[$];

  logic [63:0] prev_res;
  logic [3:0]  prev_tag;
  logic        prev_stall = 1'b0;

  // Scoreboard: transfers are judged on the falling edge before the edge that commits them.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      check_val("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_result", out_result, prev_res);
        check_val("hold_tag", out_tag, prev_tag);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check_val("spurious_out", out_valid, 0);
        else begin
          e = q.pop_front();
          popped++;
          check_val("result", out_result, e.res);
          check_val("tag", out_tag, e.tag);
        end
      end
      if (in_valid && in_ready) begin
        e.res = ref_mul(in_a, in_b, in_signed, in_high);
        e.tag = in_tag;
        q.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      prev_tag   = out_tag;
    end
  end

  task automatic one_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic h, input logic [3:0] t, input logic [63:0] exp,
                        input string name);
    int c0;
    @(posedge clock); #1;
    in_a = a; in_b = b; in_signed = s; in_high = h; in_tag = t; in_valid = 1'b1;
    c0 = cyc;
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (out_valid) break;
    end
    check_val({name, "_valid"}, out_valid, 1);
    check_val({name, "_res"}, out_result, exp);
    check_val({name, "_tag"}, out_tag, 64'(t));
    check_val({name, "_lat"}, 64'(cyc - c0), 8);
    @(posedge clock); #1;
  endtask

  task automatic small_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic h, input logic [31:0] exp, input string name);
    int c0;
    @(posedge clock); #1;
    s_in_a = a; s_in_b = b; s_in_signed = s; s_in_high = h; s_in_tag = 4'd5; s_in_valid = 1'b1;
    c0 = cyc;
    @(posedge clock); #1;
    s_in_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (s_out_valid) break;
    end
    check_val({name, "_valid"}, s_out_valid, 1);
    check_val({name, "_res"}, 64'(s_out_result), 64'(exp));
    check_val({name, "_lat"}, 64'(cyc - c0), 4);
    @(posedge clock); #1;
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] first_exp;
    int base;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_high = 1'b0;
    in_tag = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_signed = 1'b0; s_in_high = 1'b0;
    s_in_tag = '0; s_out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_result", out_result, 0);
    check_val("rst_tag", out_tag, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_small_valid", s_out_valid, 0);

    one_op(64'd3, 64'd5, 0, 0, 4'd2, 64'd15, "basic");
    one_op('1, '1, 0, 1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFE, "ones_u_hi");
    one_op('1, '1, 0, 0, 4'd4, 64'd1, "ones_u_lo");
    one_op('1, '1, 1, 1, 4'd5, 64'd0, "ones_s_hi");
    one_op('1, '1, 1, 0, 4'd6, 64'd1, "ones_s_lo");
    one_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 1, 4'd7,
           64'h4000_0000_0000_0000, "min_s_hi");
    one_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 0, 4'd8, 64'd0, "min_s_lo");
    one_op(-64'sd7, 64'd6, 1, 0, 4'd9, 64'hFFFF_FFFF_FFFF_FFD6, "neg7x6");

    // Back-to-back burst into a blocked consumer.
    base = popped;
    @(posedge clock); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_a = pick(); in_b = pick(); in_signed = 1'($urandom); in_high = 1'($urandom);
      in_tag = 4'(i); in_valid = 1'b1;
      if (i == 0) first_exp = ref_mul(in_a, in_b, in_signed, in_high);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_val("stall_valid", out_valid, 1);
      check_val("stall_in_ready", in_ready, 0);
      check_val("stall_result", out_result, first_exp);
      check_val("stall_tag", out_tag, 0);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (q.size() == 0 && !out_valid) break;
    end
    check_val("burst_drain", 64'(q.size()), 0);
    check_val("burst_count", 64'(popped - base), 8);

    // Reset with operations in flight, plus an offer during the reset cycle.
    for (int i = 0; i < 3; i++) begin
      in_a = pick(); in_b = pick(); in_tag = 4'(10 + i); in_valid = 1'b1;
      @(posedge clock); #1;
    end
    reset = 1'b1; in_tag = 4'd15;
    @(posedge clock); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check_val("flush_valid", out_valid, 0);
    check_val("flush_busy", busy, 0);
    check_val("flush_in_ready", in_ready, 1);
    check_val("flush_result", out_result, 0);
    check_val("flush_tag", out_tag, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_val("flush_quiet", out_valid, 0);
    end

    // Random traffic with random backpressure.
    @(posedge clock); #1;
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_a = pick(); in_b = pick();
      in_signed = 1'($urandom); in_high = 1'($urandom); in_tag = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (q.size() == 0 && !out_valid) break;
    end
    check_val("random_drain", 64'(q.size()), 0);
    check_val("random_idle_busy", busy, 0);

    small_op(32'hFFFF_FFFF, 32'd2, 0, 1, 32'd1, "w32_u_hi");
    small_op(32'hFFFF_FFFF, 32'd2, 0, 0, 32'hFFFF_FFFE, "w32_u_lo");
    small_op(32'hFFFF_FFFF, 32'd2, 1, 1, 32'hFFFF_FFFF, "w32_s_hi");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
